// File: rtl/ddr5_cmd_sequencer.sv
// Closed-page DDR5 command sequencer.
// Takes one request at a time from the MC queue and plays out
// ACT0/ACT1 -> RD0/RD1 or WR0/WR1 -> PRE, with programmable gaps between them.
// Only one bank is open at a time and every access ends in a precharge.
// All outputs are registered. The FSM state names the command or wait
// phase that is on the bus in the current cycle.
module ddr5_cmd_sequencer #(
  parameter int T_RCD = 8,
  parameter int T_RAS = 20,
  parameter int T_RTP = 4,
  parameter int T_CWL = 6,
  parameter int T_BL  = 4,
  parameter int T_WR  = 8,
  parameter int T_RP  = 8,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [35:0] req_addr,
  output logic [2:0]  cmd_type,
  output logic        cmd_channel,
  output logic [2:0]  cmd_bg,
  output logic [1:0]  cmd_bank,
  output logic [15:0] cmd_row,
  output logic [5:0]  cmd_col,
  output logic        done,
  output logic        err_op
);

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT0 = 3'd1,
    CMD_ACT1 = 3'd2,
    CMD_RD0  = 3'd3,
    CMD_RD1  = 3'd4,
    CMD_WR0  = 3'd5,
    CMD_WR1  = 3'd6,
    CMD_PRE  = 3'd7
  } cmd_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ACT0,
    S_ACT1,
    S_WAIT_RCD,
    S_CAS0,
    S_CAS1,
    S_WAIT_PRE,
    S_PRE,
    S_WAIT_RP
  } state_e;

  // Distance from CAS0 to PRE: the later of the tRAS bound (measured from
  // ACT0, which is tRCD earlier) and the op-specific recovery bound.
  localparam int RAS_FROM_CAS = T_RAS - T_RCD;
  localparam int WR_REC       = T_CWL + T_BL + T_WR;
  localparam int RD_GAP       = (RAS_FROM_CAS > T_RTP)  ? RAS_FROM_CAS : T_RTP;
  localparam int WR_GAP       = (RAS_FROM_CAS > WR_REC) ? RAS_FROM_CAS : WR_REC;

  // NOP cycles spent in each wait state. ACT1 and CAS1 occupy the first
  // cycle of their gaps, which gives the -2 terms below.
  localparam int RCD_WAIT = T_RCD - 2;
  localparam int RD_WAIT  = RD_GAP - 2;
  localparam int WR_WAIT  = WR_GAP - 2;
  localparam int RP_WAIT  = T_RP - 1;

  // The counter is loaded with (wait - 1) and the wait ends when it reaches zero.
  localparam logic [CNT_W-1:0] RCD_LOAD = CNT_W'(RCD_WAIT - 1);
  localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WR_WAIT - 1);
  localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(RP_WAIT - 1);

  localparam longint CNT_LIM = longint'(1) << CNT_W;
  localparam bit PARAM_OK = (T_RCD >= 2) && (T_RP >= 1) &&
                            (RD_GAP >= 2) && (WR_GAP >= 2) &&
                            (T_RAS < CNT_LIM) && (T_RCD < CNT_LIM) &&
                            (WR_REC < CNT_LIM) && (T_RP < CNT_LIM) &&
                            (RD_GAP < CNT_LIM) && (WR_GAP < CNT_LIM);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             is_wr, wr_nxt;
  logic             accept;
  cmd_e             cmd_nxt;
  logic             ready_nxt, done_nxt, err_nxt;
  cmd_e             cas0_cmd, cas1_cmd;
  logic             pre_wait_zero;
  logic [CNT_W-1:0] pre_load;
  logic             unused_addr_bits;

  // Address bits above the row and below the channel are not used by this decoder.
  assign unused_addr_bits = ^{req_addr[35:34], req_addr[5:0]};

  assign cas0_cmd      = is_wr ? CMD_WR0 : CMD_RD0;
  assign cas1_cmd      = is_wr ? CMD_WR1 : CMD_RD1;
  assign pre_wait_zero = is_wr ? (WR_WAIT == 0) : (RD_WAIT == 0);
  assign pre_load      = is_wr ? WR_LOAD : RD_LOAD;

  // State, counter and op-kind register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      is_wr <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      is_wr <= wr_nxt;
    end
  end

  // Next state and next-cycle outputs. A zero-length wait is skipped
  // by going straight to the state that follows it.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wr_nxt    = is_wr;
    accept    = 1'b0;
    cmd_nxt   = CMD_NOP;
    ready_nxt = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        ready_nxt = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (req_op == 2'd3) begin
            err_nxt = 1'b1;
          end else begin
            state_nxt = S_ACT0;
            cmd_nxt   = CMD_ACT0;
            ready_nxt = 1'b0;
            wr_nxt    = (req_op == 2'd1);
          end
        end
      end
      S_ACT0: begin
        state_nxt = S_ACT1;
        cmd_nxt   = CMD_ACT1;
      end
      S_ACT1: begin
        if (RCD_WAIT == 0) begin
          state_nxt = S_CAS0;
          cmd_nxt   = cas0_cmd;
        end else begin
          state_nxt = S_WAIT_RCD;
          cnt_nxt   = RCD_LOAD;
        end
      end
      S_WAIT_RCD: begin
        if (cnt == '0) begin
          state_nxt = S_CAS0;
          cmd_nxt   = cas0_cmd;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_CAS0: begin
        state_nxt = S_CAS1;
        cmd_nxt   = cas1_cmd;
      end
      S_CAS1: begin
        if (pre_wait_zero) begin
          state_nxt = S_PRE;
          cmd_nxt   = CMD_PRE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = S_WAIT_PRE;
          cnt_nxt   = pre_load;
        end
      end
      S_WAIT_PRE: begin
        if (cnt == '0) begin
          state_nxt = S_PRE;
          cmd_nxt   = CMD_PRE;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      S_PRE: begin
        if (RP_WAIT == 0) begin
          state_nxt = S_IDLE;
          ready_nxt = 1'b1;
        end else begin
          state_nxt = S_WAIT_RP;
          cnt_nxt   = RP_LOAD;
        end
      end
      S_WAIT_RP: begin
        if (cnt == '0) begin
          state_nxt = S_IDLE;
          ready_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        ready_nxt = 1'b1;
      end
    endcase
  end

  // Registered command bus. The address fields hold the last accepted request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_ready   <= 1'b1;
      cmd_type    <= CMD_NOP;
      done        <= 1'b0;
      err_op      <= 1'b0;
      cmd_channel <= 1'b0;
      cmd_bg      <= '0;
      cmd_bank    <= '0;
      cmd_row     <= '0;
      cmd_col     <= '0;
    end else begin
      req_ready <= ready_nxt;
      cmd_type  <= cmd_nxt;
      done      <= done_nxt;
      err_op    <= err_nxt;
      if (accept) begin
        cmd_channel <= req_addr[6];
        cmd_bg      <= req_addr[9:7];
        cmd_bank    <= req_addr[11:10];
        cmd_row     <= req_addr[33:18];
        cmd_col     <= req_addr[17:12];
      end
    end
  end

  // Flags a timing parameter set that the counter or the state sequence cannot honour.
  always_ff @(posedge clk) begin
    param_ok_a: assert (PARAM_OK)
      else $error("ddr5_cmd_sequencer: illegal timing parameters");
  end

endmodule

// File: tb/tb_ddr5_cmd_sequencer.sv
// Bench for ddr5_cmd_sequencer: a per-cycle expected-output table is filled
// from the timing rules whenever a request is accepted, then compared with the
// DUT every cycle. Directed scenarios also check hard-coded cycle numbers.
module tb_ddr5_cmd_sequencer;
  localparam int T_RCD = 8, T_RAS = 20, T_RTP = 4, T_CWL = 6, T_BL = 4,
                 T_WR = 8, T_RP = 8, CNT_W = 8;
  localparam int MAXC = 4000;
  localparam logic [35:0] ADDR = 36'h0_48D0_3AC0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [35:0] req_addr = '0;
  logic [2:0]  cmd_type;
  logic        cmd_channel;
  logic [2:0]  cmd_bg;
  logic [1:0]  cmd_bank;
  logic [15:0] cmd_row;
  logic [5:0]  cmd_col;
  logic        done;
  logic        err_op;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Expected value of each output after clock edge number c.
  logic        m_ready [MAXC];
  logic [2:0]  m_cmd   [MAXC];
  logic        m_done  [MAXC];
  logic        m_err   [MAXC];
  logic [27:0] m_fld   [MAXC];

  logic [33:0] obs;
  assign obs = {req_ready, cmd_type, done, err_op, cmd_channel, cmd_bg, cmd_bank, cmd_row, cmd_col};

  ddr5_cmd_sequencer #(
    .T_RCD(T_RCD), .T_RAS(T_RAS), .T_RTP(T_RTP), .T_CWL(T_CWL),
    .T_BL(T_BL), .T_WR(T_WR), .T_RP(T_RP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .cmd_type(cmd_type),
    .cmd_channel(cmd_channel), .cmd_bg(cmd_bg), .cmd_bank(cmd_bank),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .done(done), .err_op(err_op)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [33:0] exp_vec(input int c);
    return {m_ready[c], m_cmd[c], m_done[c], m_err[c], m_fld[c]};
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Reset sampled at edge r: idle values from r onwards, in-flight request gone.
  task automatic model_reset(input int r);
    for (int k = r; k < MAXC; k++) begin
      m_ready[k] = 1'b1; m_cmd[k] = 3'd0; m_done[k] = 1'b0;
      m_err[k] = 1'b0;   m_fld[k] = '0;
    end
  endtask

  // Request accepted while ready was visible in cycle t0.
  task automatic model_accept(input int t0, input logic [1:0] op, input logic [35:0] a);
    int act, cas, pre;
    logic wr;
    logic [27:0] f;
    f = {a[6], a[9:7], a[11:10], a[33:18], a[17:12]};
    for (int k = t0 + 1; k < MAXC; k++) m_fld[k] = f;
    if (op == 2'd3) begin
      m_err[t0 + 1] = 1'b1;
      return;
    end
    wr  = (op == 2'd1);
    act = t0 + 1;
    cas = act + T_RCD;
    pre = wr ? imax(act + T_RAS, cas + T_CWL + T_BL + T_WR)
             : imax(act + T_RAS, cas + T_RTP);
    m_cmd[act] = 3'd1; m_cmd[act + 1] = 3'd2;
    m_cmd[cas] = wr ? 3'd5 : 3'd3;
    m_cmd[cas + 1] = wr ? 3'd6 : 3'd4;
    m_cmd[pre] = 3'd7; m_done[pre] = 1'b1;
    for (int k = act; k < pre + T_RP; k++) m_ready[k] = 1'b0;
  endtask

  // Drive inputs for the current cycle, update the model, advance one cycle.
  task automatic tick(input logic v, input logic [1:0] op, input logic [35:0] a, input logic rst);
    req_valid = v; req_op = op; req_addr = a; rst_n = rst;
    if (!rst) model_reset(cyc + 1);
    else if (v && m_ready[cyc]) model_accept(cyc, op, a);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) tick(1'b1, 2'd0, ADDR, 1'b0);
    total++;
    if (obs !== 34'h2_0000_0000) begin
      bad++; $display("FAIL reset_values got=%h exp=%h", obs, 34'h2_0000_0000);
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 2'd0, '0, 1'b1);
      total++;
      if (obs !== exp_vec(cyc)) begin
        bad++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, obs, exp_vec(cyc));
      end
    end
  endtask

  task automatic test_read;
    for (int i = 1; i <= 30; i++) begin
      tick(i == 1, 2'd0, ADDR, 1'b1);
      total++;
      if (obs !== exp_vec(cyc)) begin
        bad++; $display("FAIL read_trace i=%0d got=%h exp=%h", i, obs, exp_vec(cyc));
      end
      if (i == 1) begin
        total++;
        if ({cmd_type, cmd_channel, cmd_bg, cmd_bank, cmd_row, req_ready} !==
            {3'd1, 1'b1, 3'd5, 2'd2, 16'h1234, 1'b0}) begin
          bad++; $display("FAIL read_act0 got cmd=%0d ch=%0d bg=%0d bank=%0d row=%h rdy=%0d exp cmd=1 ch=1 bg=5 bank=2 row=1234 rdy=0",
                          cmd_type, cmd_channel, cmd_bg, cmd_bank, cmd_row, req_ready);
        end
      end
      if (i == 9) begin
        total++;
        if ({cmd_type, cmd_col} !== {3'd3, 6'd3}) begin
          bad++; $display("FAIL read_rd0 got cmd=%0d col=%0d exp cmd=3 col=3", cmd_type, cmd_col);
        end
      end
      if (i == 21) begin
        total++;
        if ({cmd_type, done} !== {3'd7, 1'b1}) begin
          bad++; $display("FAIL read_pre got cmd=%0d done=%0d exp cmd=7 done=1", cmd_type, done);
        end
      end
      if (i == 28 || i == 29) begin
        total++;
        if (req_ready !== (i == 29)) begin
          bad++; $display("FAIL read_ready i=%0d got=%0d exp=%0d", i, req_ready, (i == 29));
        end
      end
    end
  endtask

  task automatic test_write;
    for (int i = 1; i <= 36; i++) begin
      tick(i == 1, 2'd1, ADDR, 1'b1);
      total++;
      if (obs !== exp_vec(cyc)) begin
        bad++; $display("FAIL write_trace i=%0d got=%h exp=%h", i, obs, exp_vec(cyc));
      end
      if (i == 9 || i == 10) begin
        total++;
        if (cmd_type !== ((i == 9) ? 3'd5 : 3'd6)) begin
          bad++; $display("FAIL write_cas i=%0d got=%0d exp=%0d", i, cmd_type, (i == 9) ? 5 : 6);
        end
      end
      if (i == 21 || i == 27) begin
        total++;
        if ({cmd_type, done} !== ((i == 27) ? {3'd7, 1'b1} : {3'd0, 1'b0})) begin
          bad++; $display("FAIL write_pre i=%0d got cmd=%0d done=%0d", i, cmd_type, done);
        end
      end
      if (i == 34 || i == 35) begin
        total++;
        if (req_ready !== (i == 35)) begin
          bad++; $display("FAIL write_ready i=%0d got=%0d exp=%0d", i, req_ready, (i == 35));
        end
      end
    end
  endtask

  task automatic test_ifetch;
    for (int i = 1; i <= 30; i++) begin
      tick(i == 1, 2'd2, ADDR, 1'b1);
      total++;
      if (obs !== exp_vec(cyc)) begin
        bad++; $display("FAIL ifetch_trace i=%0d got=%h exp=%h", i, obs, exp_vec(cyc));
      end
      if (i == 10 || i == 21) begin
        total++;
        if (cmd_type !== ((i == 10) ? 3'd4 : 3'd7)) begin
          bad++; $display("FAIL ifetch_cmd i=%0d got=%0d exp=%0d", i, cmd_type, (i == 10) ? 4 : 7);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 1; i <= 62; i++) begin
      tick(i <= 40, 2'd0, ADDR, 1'b1);
      total++;
      if (obs !== exp_vec(cyc)) begin
        bad++; $display("FAIL b2b_trace i=%0d got=%h exp=%h", i, obs, exp_vec(cyc));
      end
      if (i >= 22 && i <= 29) begin
        total++;
        if (cmd_type !== 3'd0) begin
          bad++; $display("FAIL b2b_gap i=%0d got=%0d exp=0", i, cmd_type);
        end
      end
      if (i == 30 || i == 50) begin
        total++;
        if (cmd_type !== ((i == 30) ? 3'd1 : 3'd7)) begin
          bad++; $display("FAIL b2b_second i=%0d got=%0d exp=%0d", i, cmd_type, (i == 30) ? 1 : 7);
        end
      end
    end
  endtask

  task automatic test_err_op;
    for (int i = 1; i <= 6; i++) begin
      tick(i == 1, 2'd3, ADDR, 1'b1);
      total++;
      if (obs !== exp_vec(cyc)) begin
        bad++; $display("FAIL err_trace i=%0d got=%h exp=%h", i, obs, exp_vec(cyc));
      end
      total++;
      if ({err_op, cmd_type, req_ready} !== {(i == 1), 3'd0, 1'b1}) begin
        bad++; $display("FAIL err_pulse i=%0d got err=%0d cmd=%0d rdy=%0d exp err=%0d cmd=0 rdy=1",
                        i, err_op, cmd_type, req_ready, (i == 1));
      end
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 1; i <= 45; i++) begin
      tick(i == 1 || i == 14, 2'd0, ADDR, i != 11);
      total++;
      if (obs !== exp_vec(cyc)) begin
        bad++; $display("FAIL rstmid_trace i=%0d got=%h exp=%h", i, obs, exp_vec(cyc));
      end
      if (i == 9 || i == 11 || i == 14 || i == 21 || i == 22 || i == 34) begin
        total++;
        if (cmd_type !== ((i == 9 || i == 22) ? 3'd3 : (i == 14) ? 3'd1 : (i == 34) ? 3'd7 : 3'd0)) begin
          bad++; $display("FAIL rstmid_cmd i=%0d got=%0d", i, cmd_type);
        end
      end
      if (i == 11) begin
        total++;
        if ({req_ready, done} !== 2'b10) begin
          bad++; $display("FAIL rstmid_ready got rdy=%0d done=%0d exp rdy=1 done=0", req_ready, done);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [63:0] r;
    logic [1:0]  op;
    int sel;
    for (int i = 0; i < 1500; i++) begin
      r = {$urandom(), $urandom()};
      sel = $urandom_range(0, 9);
      op = (sel < 4) ? 2'd0 : (sel < 7) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
      tick($urandom_range(0, 3) != 0, op, r[35:0], $urandom_range(0, 249) != 0);
      total++;
      if (obs !== exp_vec(cyc)) begin
        bad++; $display("FAIL random_trace cyc=%0d got=%h exp=%h", cyc, obs, exp_vec(cyc));
      end
    end
    for (int i = 0; i < 45; i++) begin
      tick(1'b0, 2'd0, '0, 1'b1);
      total++;
      if (obs !== exp_vec(cyc)) begin
        bad++; $display("FAIL random_drain cyc=%0d got=%h exp=%h", cyc, obs, exp_vec(cyc));
      end
    end
  endtask

  initial begin
    model_reset(0);
    @(negedge clk);
    test_reset;
    test_read;
    test_write;
    test_ifetch;
    test_back_to_back;
    test_err_op;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
